// File: rtl/alu_issuer_if.sv
// Bundles the decode-side request, ALU operand/result and writeback-side result handshakes.
// The master modport is the issuer; the slave modport is the surrounding pipeline and ALU.
interface alu_issuer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_r;
  logic             alu_zf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_zf;
  logic             out_dz;

  modport master (
    input  in_valid, in_a, in_b, in_sel, alu_r, alu_zf, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_r, out_zf, out_dz
  );

  modport slave (
    output in_valid, in_a, in_b, in_sel, alu_r, alu_zf, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_r, out_zf, out_dz
  );
endinterface

// File: rtl/alu_issuer.sv
// Issues one op at a time to a combinational ALU, waits an op-dependent settle time,
// then returns the captured result; divide-by-zero is answered locally.
module alu_issuer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_issuer_if.master  bus
);
  localparam int unsigned CNT_W   = 4;
  localparam logic [2:0]  SEL_MUL = 3'd5;
  localparam logic [2:0]  SEL_DIV = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_div0;
  logic             w_capture;
  logic [CNT_W-1:0] w_load_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_zf;
  logic             r_out_dz;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_div0     = 1'b0;
    w_capture  = 1'b0;
    w_load_cnt = '0;
    case (bus.in_sel)
      SEL_MUL: w_load_cnt = CNT_W'(MUL_WAIT);
      SEL_DIV: w_load_cnt = CNT_W'(DIV_WAIT);
      default: w_load_cnt = '0;
    endcase
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (bus.in_sel == SEL_DIV && bus.in_b == '0) begin
            w_div0 = 1'b1;
            w_next = S_DONE;
          end else begin
            w_next = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake flags track the next state so they are flops, not state decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_out_r   <= '0;
      r_out_zf  <= 1'b0;
      r_out_dz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= bus.in_a;
        r_alu_b   <= bus.in_b;
        r_alu_sel <= bus.in_sel;
        if (w_div0) begin
          r_out_r  <= '0;
          r_out_zf <= 1'b1;
          r_out_dz <= 1'b1;
        end else begin
          r_cnt    <= w_load_cnt;
          r_out_dz <= 1'b0;
        end
      end
      if (r_state == S_EXEC && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (w_capture) begin
        r_out_r  <= bus.alu_r;
        r_out_zf <= bus.alu_zf;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.out_r     = r_out_r;
  assign bus.out_zf    = r_out_zf;
  assign bus.out_dz    = r_out_dz;
endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: behavioural ALU on the bus, directed spec cases, then random ops
// checked against an op-level model of result, flags and latency.
module tb_alu_issuer;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MUL_WAIT = 2;
  localparam int unsigned DIV_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issuer_if #(.WIDTH(WIDTH)) bus ();

  alu_issuer #(.WIDTH(WIDTH), .MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return 32'(a * b);
      3'd6: return (b == 32'd0) ? 32'd0 : a / b;
      default: return b;
    endcase
  endfunction

  // Combinational ALU sitting on the issuer's operand bus.
  assign bus.alu_r  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign bus.alu_zf = (alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel) == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, keeps junk on the input side while busy, holds DONE for `hold` cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                        input int hold, output logic [31:0] r_obs, output logic zf_obs,
                        output logic dz_obs, output int lat_obs);
    logic        dz;
    logic [31:0] er;
    int          lat;
    int          edges;
    logic [31:0] sr;
    logic        szf;
    logic        sdz;
    dz  = (sel == 3'd6) && (b == 32'd0);
    er  = dz ? 32'd0 : alu_fn(a, b, sel);
    lat = dz ? 1 : (sel == 3'd5) ? 2 + int'(MUL_WAIT) : (sel == 3'd6) ? 2 + int'(DIV_WAIT) : 2;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    tick();
    edges = 1;
    bus.in_valid = 1'b1;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_sel   = 3'($urandom);
    while (bus.out_valid !== 1'b1 && edges < 64) begin
      chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
      chk("exec_alu_a", bus.alu_a, a);
      chk("exec_alu_b", bus.alu_b, b);
      chk("exec_alu_sel", 32'(bus.alu_sel), 32'(sel));
      bus.out_ready = 1'($urandom);
      tick();
      edges++;
    end
    bus.out_ready = 1'b0;
    lat_obs = edges;
    chk("latency", 32'(edges), 32'(lat));
    chk("done_out_r", bus.out_r, er);
    chk("done_out_zf", 32'(bus.out_zf), 32'(er == 32'd0));
    chk("done_out_dz", 32'(bus.out_dz), 32'(dz));
    sr  = bus.out_r;
    szf = bus.out_zf;
    sdz = bus.out_dz;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_r", bus.out_r, sr);
      chk("hold_out_flags", {30'd0, bus.out_zf, bus.out_dz}, {30'd0, szf, sdz});
      chk("hold_alu_a", bus.alu_a, a);
      chk("hold_alu_sel", 32'(bus.alu_sel), 32'(sel));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    r_obs  = sr;
    zf_obs = szf;
    dz_obs = sdz;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        zf;
    logic        dz;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("rst_out_r", bus.out_r, 32'd0);
    chk("rst_out_flags", {30'd0, bus.out_zf, bus.out_dz}, 32'd0);

    run_op(32'd5, 32'd7, 3'd0, 0, r, zf, dz, lat);
    chk("add_r", r, 32'd12);
    chk("add_flags", {30'd0, zf, dz}, 32'd0);
    chk("add_lat", 32'(lat), 32'd2);

    run_op(32'd9, 32'd9, 3'd1, 1, r, zf, dz, lat);
    chk("sub_r", r, 32'd0);
    chk("sub_zf", 32'(zf), 32'd1);

    run_op(32'd100, 32'd7, 3'd6, 0, r, zf, dz, lat);
    chk("div_r", r, 32'd14);
    chk("div_lat", 32'(lat), 32'd6);

    run_op(32'd42, 32'd0, 3'd6, 0, r, zf, dz, lat);
    chk("div0_r", r, 32'd0);
    chk("div0_flags", {30'd0, zf, dz}, 32'd3);
    chk("div0_lat", 32'(lat), 32'd1);

    run_op(32'hFFFF_0001, 32'h0000_0010, 3'd3, 5, r, zf, dz, lat);
    chk("bp_r", r, 32'hFFFF_0011);

    run_op(32'h8000_0000, 32'd1, 3'd4, 0, r, zf, dz, lat);
    chk("slt_r", r, 32'd1);

    run_op(32'h0001_0000, 32'h0001_0000, 3'd5, 0, r, zf, dz, lat);
    chk("mul_trunc_r", r, 32'd0);
    chk("mul_lat", 32'(lat), 32'd4);

    // Reset while a multiply is still settling.
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd3;
    bus.in_b     = 32'd4;
    bus.in_sel   = 3'd5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mulrst_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mulrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mulrst_alu", bus.alu_a | bus.alu_b | 32'(bus.alu_sel), 32'd0);
    chk("mulrst_out", bus.out_r | {30'd0, bus.out_zf, bus.out_dz}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mulrst_no_valid", 32'(bus.out_valid), 32'd0);
      chk("mulrst_idle", 32'(bus.in_ready), 32'd1);
    end

    for (int n = 0; n < 40; n++) begin
      sel = 3'($urandom_range(0, 7));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = a;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      run_op(a, b, sel, int'($urandom_range(0, 3)), r, zf, dz, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
